field_row: RTL

Parametrised row controller for the LED playfield. Each instance owns one row: a pipe shift register (green plane), bird occupancy (red plane), collision detection and gate-pass signalling. Instances are chained vertically through bird-neighbour signals. A top-level aggregator ORs the `hit` outputs into `halt` and counts `gate_pulse` for scoring.

---
 rtl/flappy_pkg.sv | 13 +
 rtl/pipe_shifter.sv | 23 ++
 rtl/field_row.sv | 112 +++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared types and default geometry for the LED playfield rows.
package flappy_pkg;

   typedef enum logic [1:0] {
      ROW_EMPTY   = 2'd0,
      ROW_BIRD    = 2'd1,
      ROW_CRASHED = 2'd2
   } row_state_t;

   localparam int FIELD_W        = 16;
   localparam int FIELD_BIRD_COL = 11;

endpackage

// File: rtl/pipe_shifter.sv
// Enable-gated serial-in shift register; column 0 takes the serial bit and the MSB falls off.
module pipe_shifter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_din,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset)
         r_q <= '0;
      else if (i_en)
         r_q <= {r_q[WIDTH-2:0], i_din};
   end

   assign o_q = r_q;

endmodule

// File: rtl/field_row.sv
// One playfield row: bird FSM, sticky collision flag, crash blink and gate-pass strobe
// around a scrolling pipe register.
module field_row
   import flappy_pkg::*;
#(
   parameter int WIDTH      = FIELD_W,
   parameter int BIRD_COL   = FIELD_BIRD_COL,
   parameter bit START_BIRD = 1'b0,
   parameter bit IS_TOP     = 1'b0,
   parameter bit IS_BOTTOM  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_grav,
   input  logic             tick_scroll,
   input  logic             pipe_in,
   input  logic             flap,
   input  logic             halt,
   input  logic             bird_above_in,
   input  logic             bird_below_in,
   output logic             bird_out,
   output logic             hit,
   output logic             gate_pulse,
   output logic [WIDTH-1:0] grn_row,
   output logic [WIDTH-1:0] red_row
);

   row_state_t       r_state;
   row_state_t       w_next;
   logic             r_hit;
   logic             r_blink;
   logic             r_gate;
   logic             w_step;
   logic             w_scroll;
   logic             w_load_bit;
   logic             w_enter_crash;
   logic [WIDTH-1:0] w_grn;

   assign w_step   = tick_grav & ~halt;
   assign w_scroll = tick_scroll & ~halt;

   pipe_shifter #(.WIDTH(WIDTH)) u_pipe (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_scroll),
      .i_din (pipe_in),
      .o_q   (w_grn)
   );

   // Bit that a scroll would place under the bird column.
   generate
      if (BIRD_COL == 0) begin : g_col0
         assign w_load_bit = pipe_in;
      end else begin : g_coln
         assign w_load_bit = w_grn[BIRD_COL-1];
      end
   endgenerate

   // A step outranks the pipe check, so a bird leaving a pipe cell escapes.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ROW_EMPTY: begin
            if (w_step && ((flap && bird_below_in) || (!flap && bird_above_in)))
               w_next = ROW_BIRD;
         end
         ROW_BIRD: begin
            if (w_step) begin
               if ((flap && IS_TOP) || (!flap && IS_BOTTOM))
                  w_next = ROW_CRASHED;
               else
                  w_next = ROW_EMPTY;
            end else if (!halt && w_grn[BIRD_COL]) begin
               w_next = ROW_CRASHED;
            end
         end
         default: w_next = r_state;
      endcase
   end

   assign w_enter_crash = (w_next == ROW_CRASHED) && (r_state != ROW_CRASHED);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= START_BIRD ? ROW_BIRD : ROW_EMPTY;
         r_hit   <= 1'b0;
         r_blink <= 1'b0;
         r_gate  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_enter_crash)
            r_hit <= 1'b1;
         if (w_enter_crash)
            r_blink <= 1'b1;
         else if (tick_grav)
            r_blink <= ~r_blink;
         // Requiring EMPTY on both sides of the edge keeps the strobe out of BIRD.
         r_gate <= w_scroll && w_load_bit && (r_state == ROW_EMPTY) && (w_next == ROW_EMPTY);
      end
   end

   always_comb begin
      red_row           = '0;
      red_row[BIRD_COL] = (r_state == ROW_BIRD) || ((r_state == ROW_CRASHED) && r_blink);
   end

   assign bird_out   = (r_state == ROW_BIRD) || (r_state == ROW_CRASHED);
   assign hit        = r_hit;
   assign gate_pulse = r_gate;
   assign grn_row    = w_grn;

endmodule
